// File: rtl/dnoc_addr_gen_pkg.sv
// Shared types and default sizing for the DNOC nested-loop address generator.
package dnoc_addr_gen_pkg;

  localparam int DEF_ADDR_W   = 13;
  localparam int DEF_CNT_W    = 13;
  localparam int DEF_NUM_LOOP = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/dnoc_addr_loop.sv
// One loop level: counter plus accumulated offset, with look-ahead of the post-step values.
module dnoc_addr_loop
  import dnoc_addr_gen_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step,
  input  logic              clr,
  input  logic [ADDR_W-1:0] gap,
  input  logic [CNT_W-1:0]  lenth,
  output logic              at_term,
  output logic [ADDR_W-1:0] off_nxt,
  output logic              term_nxt
);

  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [ADDR_W-1:0] off_reg, off_next;

  assign at_term = (cnt_reg == lenth);

  always_comb begin
    cnt_next = cnt_reg;
    off_next = off_reg;
    if (step) begin
      if (at_term) begin
        cnt_next = '0;
        off_next = '0;
      end else begin
        cnt_next = cnt_reg + 1'b1;
        off_next = off_reg + gap;
      end
    end
  end

  // The top registers the next address from these, so the adder sees post-step offsets.
  assign off_nxt  = off_next;
  assign term_nxt = (cnt_next == lenth);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
      off_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
      off_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
      off_reg <= off_next;
    end
  end

endmodule

// File: rtl/dnoc_addr_gen.sv
// N-level nested-loop address generator with start/busy/done control and a valid/ready address port.
module dnoc_addr_gen
  import dnoc_addr_gen_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int NUM_LOOP = DEF_NUM_LOOP
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [ADDR_W-1:0]                cfg_base_addr,
  input  logic [NUM_LOOP-1:0][ADDR_W-1:0]  cfg_gap,
  input  logic [NUM_LOOP-1:0][CNT_W-1:0]   cfg_lenth,
  input  logic                             start,
  input  logic                             abort,
  output logic                             addr_valid,
  input  logic                             addr_ready,
  output logic [ADDR_W-1:0]                addr,
  output logic                             addr_last,
  output logic                             busy,
  output logic                             done
);

  state_t state_reg, state_next;

  logic [ADDR_W-1:0]               base_reg;
  logic [NUM_LOOP-1:0][ADDR_W-1:0] gap_reg;
  logic [NUM_LOOP-1:0][CNT_W-1:0]  lenth_reg;

  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              valid_reg, valid_next;
  logic              last_reg, last_next;
  logic              done_reg, done_next;
  logic              load_cfg, clr, adv;
  logic              fire;

  logic [NUM_LOOP-1:0]             at_term, term_nxt;
  logic [NUM_LOOP-1:0][ADDR_W-1:0] off_nxt;
  logic [NUM_LOOP:0]               term_chain, nxt_chain, zero_chain;
  logic [ADDR_W-1:0]               psum [NUM_LOOP+1];

  assign fire = valid_reg & addr_ready;

  assign term_chain[0] = 1'b1;
  assign nxt_chain[0]  = 1'b1;
  assign zero_chain[0] = 1'b1;
  assign psum[0]       = base_reg;

  // Loop gi steps only when every inner loop sits at its terminal count.
  for (genvar gi = 0; gi < NUM_LOOP; gi++) begin : g_loop
    dnoc_addr_loop #(
      .ADDR_W(ADDR_W),
      .CNT_W (CNT_W)
    ) u_loop (
      .clk     (clk),
      .rst_n   (rst_n),
      .step    (adv & term_chain[gi]),
      .clr     (clr),
      .gap     (gap_reg[gi]),
      .lenth   (lenth_reg[gi]),
      .at_term (at_term[gi]),
      .off_nxt (off_nxt[gi]),
      .term_nxt(term_nxt[gi])
    );
    assign term_chain[gi+1] = term_chain[gi] & at_term[gi];
    assign nxt_chain[gi+1]  = nxt_chain[gi] & term_nxt[gi];
    assign zero_chain[gi+1] = zero_chain[gi] & (cfg_lenth[gi] == '0);
    assign psum[gi+1]       = psum[gi] + off_nxt[gi];
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    valid_next = valid_reg;
    last_next  = last_reg;
    done_next  = 1'b0;
    load_cfg   = 1'b0;
    clr        = 1'b0;
    adv        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start && !abort) begin
          state_next = RUN;
          load_cfg   = 1'b1;
          clr        = 1'b1;
          addr_next  = cfg_base_addr;
          valid_next = 1'b1;
          last_next  = zero_chain[NUM_LOOP];
        end
      end
      RUN: begin
        if (abort) begin
          state_next = IDLE;
          valid_next = 1'b0;
          last_next  = 1'b0;
          clr        = 1'b1;
        end else if (fire) begin
          if (term_chain[NUM_LOOP]) begin
            state_next = IDLE;
            valid_next = 1'b0;
            last_next  = 1'b0;
            done_next  = 1'b1;
            clr        = 1'b1;
          end else begin
            adv        = 1'b1;
            addr_next  = psum[NUM_LOOP];
            last_next  = nxt_chain[NUM_LOOP];
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      base_reg  <= '0;
      gap_reg   <= '0;
      lenth_reg <= '0;
      addr_reg  <= '0;
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      valid_reg <= valid_next;
      last_reg  <= last_next;
      done_reg  <= done_next;
      if (load_cfg) begin
        base_reg  <= cfg_base_addr;
        gap_reg   <= cfg_gap;
        lenth_reg <= cfg_lenth;
      end
    end
  end

  assign addr_valid = valid_reg;
  assign addr       = addr_reg;
  assign addr_last  = last_reg;
  assign busy       = (state_reg == RUN);
  assign done       = done_reg;

endmodule

// File: tb/tb_dnoc_addr_gen.sv
// Randomized self-checking bench for dnoc_addr_gen against an index-decomposition address model.
module tb_dnoc_addr_gen;

  localparam int AW = 13;
  localparam int CW = 13;
  localparam int NL = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0]          cfg_base_addr = '0;
  logic [NL-1:0][AW-1:0]  cfg_gap = '0;
  logic [NL-1:0][CW-1:0]  cfg_lenth = '0;
  logic start = 1'b0, abort = 1'b0, addr_ready = 1'b0;
  logic addr_valid, addr_last, busy, done;
  logic [AW-1:0] addr;

  dnoc_addr_gen #(.ADDR_W(AW), .CNT_W(CW), .NUM_LOOP(NL)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_base_addr(cfg_base_addr),
    .cfg_gap      (cfg_gap),
    .cfg_lenth    (cfg_lenth),
    .start        (start),
    .abort        (abort),
    .addr_valid   (addr_valid),
    .addr_ready   (addr_ready),
    .addr         (addr),
    .addr_last    (addr_last),
    .busy         (busy),
    .done         (done)
  );

  int checks = 0;
  int failures = 0;

  int m_base;
  int m_gap[NL];
  int m_len[NL];
  int exp_q[$];

  int cap_addr[$];
  int cap_last[$];
  int cap_busy, cap_hold_err;
  bit cap_timeout, cap_first_valid, cap_end_valid, cap_end_done, cap_end_busy;

  // Address k of the sequence: decompose k in mixed radix (lenth_i+1), loop 0 least significant.
  function automatic void build_expected();
    longint total = 1;
    exp_q.delete();
    for (int i = 0; i < NL; i++) total = total * (m_len[i] + 1);
    for (longint k = 0; k < total; k++) begin
      longint rem = k;
      longint sum = m_base;
      for (int i = 0; i < NL; i++) begin
        sum = sum + (rem % (m_len[i] + 1)) * m_gap[i];
        rem = rem / (m_len[i] + 1);
      end
      exp_q.push_back(int'(sum % 8192));
    end
  endfunction

  function automatic logic pick_ready(input int mode, input int idx);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (idx % 3) == 0;
    return $urandom_range(0, 3) != 0;
  endfunction

  task automatic set_model(input int base, input int g0, input int g1, input int g2, input int g3,
                           input int l0, input int l1, input int l2, input int l3);
    m_base = base;
    m_gap[0] = g0; m_gap[1] = g1; m_gap[2] = g2; m_gap[3] = g3;
    m_len[0] = l0; m_len[1] = l1; m_len[2] = l2; m_len[3] = l3;
  endtask

  task automatic apply_cfg();
    cfg_base_addr = AW'(m_base);
    for (int i = 0; i < NL; i++) begin
      cfg_gap[i]   = AW'(m_gap[i]);
      cfg_lenth[i] = CW'(m_len[i]);
    end
  endtask

  // Starts one sequence and records every fired address; abort_at>0 aborts on that fire.
  task automatic capture(input int mode, input int abort_at, input bit disturb);
    bit first = 1'b1;
    bit prev_stall = 1'b0;
    bit finished = 1'b0;
    int idx = 0;
    logic [AW-1:0] prev_addr = '0;
    logic prev_last = 1'b0;
    cap_addr.delete(); cap_last.delete();
    cap_busy = 0; cap_hold_err = 0; cap_timeout = 0;
    cap_end_valid = 0; cap_end_done = 0; cap_end_busy = 0;
    @(posedge clk); #1;
    apply_cfg();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    addr_ready = pick_ready(mode, idx++);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (first) begin cap_first_valid = addr_valid; first = 1'b0; end
      if (busy) cap_busy++;
      if (prev_stall && (addr !== prev_addr || addr_last !== prev_last || addr_valid !== 1'b1))
        cap_hold_err++;
      if (addr_valid && addr_ready) begin
        cap_addr.push_back(int'(addr));
        cap_last.push_back(int'(addr_last));
        if (abort_at > 0 && cap_addr.size() == abort_at) begin
          abort = 1'b1; start = 1'b0;
          @(posedge clk); #1;
          abort = 1'b0;
          @(negedge clk);
          cap_end_valid = addr_valid; cap_end_done = done; cap_end_busy = busy;
          finished = 1'b1;
          break;
        end
        if (addr_last) begin
          start = 1'b0;
          @(posedge clk);
          @(negedge clk);
          cap_end_valid = addr_valid; cap_end_done = done; cap_end_busy = busy;
          finished = 1'b1;
          break;
        end
      end
      prev_stall = addr_valid && !addr_ready;
      prev_addr = addr;
      prev_last = addr_last;
      @(posedge clk); #1;
      addr_ready = pick_ready(mode, idx++);
      if (disturb) begin
        start = 1'($urandom_range(0, 1));
        cfg_base_addr = AW'($urandom);
        cfg_gap = {NL{AW'($urandom)}};
        cfg_lenth = {NL{CW'($urandom_range(0, 7))}};
      end
    end
    start = 1'b0;
    if (!finished) cap_timeout = 1'b1;
    $display("seq: base=0x%0h fires=%0d busy_cycles=%0d end_done=%0b", m_base, cap_addr.size(), cap_busy, cap_end_done);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({addr_valid, addr_last, busy, done} !== 4'b0 || addr !== '0) begin
      failures++;
      $display("FAIL reset: valid=%b last=%b busy=%b done=%b addr=0x%0h, required all 0", addr_valid, addr_last, busy, done, addr);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lit[8] = '{'h100, 'h101, 'h102, 'h103, 'h110, 'h111, 'h112, 'h113};
    set_model('h100, 1, 'h10, 0, 0, 3, 1, 0, 0);
    capture(0, 0, 1'b0);
    checks++;
    if (cap_timeout || cap_addr.size() != 8) begin
      failures++;
      $display("FAIL basic_count: got %0d addresses timeout=%0b, required 8", cap_addr.size(), cap_timeout);
    end
    for (int i = 0; i < cap_addr.size() && i < 8; i++) begin
      checks++;
      if (cap_addr[i] != lit[i] || cap_last[i] != int'(i == 7)) begin
        failures++;
        $display("FAIL basic_addr[%0d]: got 0x%0h last=%0d, required 0x%0h last=%0d", i, cap_addr[i], cap_last[i], lit[i], i == 7);
      end
    end
    checks++;
    if (!cap_first_valid || cap_busy != 8 || !cap_end_done || cap_end_valid || cap_end_busy) begin
      failures++;
      $display("FAIL basic_ctrl: first_valid=%0b busy=%0d done=%0b valid=%0b busy_end=%0b, required 1 8 1 0 0",
               cap_first_valid, cap_busy, cap_end_done, cap_end_valid, cap_end_busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL basic_done_pulse: done=%b one cycle later, required 0", done);
    end
  endtask

  task automatic test_backpressure();
    set_model('h100, 1, 'h10, 0, 0, 3, 1, 0, 0);
    build_expected();
    capture(1, 0, 1'b0);
    checks++;
    if (cap_timeout || cap_addr.size() != exp_q.size() || cap_hold_err != 0 || !cap_end_done) begin
      failures++;
      $display("FAIL bp_ctrl: n=%0d hold_err=%0d done=%0b timeout=%0b, required n=%0d hold_err=0 done=1",
               cap_addr.size(), cap_hold_err, cap_end_done, cap_timeout, exp_q.size());
    end
    for (int i = 0; i < cap_addr.size() && i < exp_q.size(); i++) begin
      checks++;
      if (cap_addr[i] != exp_q[i]) begin
        failures++;
        $display("FAIL bp_addr[%0d]: got 0x%0h, required 0x%0h", i, cap_addr[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_single();
    set_model('h1FFF, 5, 6, 7, 8, 0, 0, 0, 0);
    capture(0, 0, 1'b0);
    checks++;
    if (cap_addr.size() != 1 || cap_addr[0] != 'h1FFF || cap_last[0] != 1 || !cap_end_done || cap_busy != 1) begin
      failures++;
      $display("FAIL single: n=%0d addr=0x%0h last=%0d done=%0b busy=%0d, required 1 0x1fff 1 1 1",
               cap_addr.size(), cap_addr.size() > 0 ? cap_addr[0] : -1, cap_last.size() > 0 ? cap_last[0] : -1,
               cap_end_done, cap_busy);
    end
  endtask

  task automatic test_wrap();
    int lit[3] = '{'h1FF0, 'h0010, 'h0030};
    set_model('h1FF0, 'h20, 0, 0, 0, 2, 0, 0, 0);
    capture(2, 0, 1'b0);
    checks++;
    if (cap_addr.size() != 3 || !cap_end_done) begin
      failures++;
      $display("FAIL wrap_count: got %0d done=%0b, required 3 done=1", cap_addr.size(), cap_end_done);
    end
    for (int i = 0; i < cap_addr.size() && i < 3; i++) begin
      checks++;
      if (cap_addr[i] != lit[i]) begin
        failures++;
        $display("FAIL wrap_addr[%0d]: got 0x%0h, required 0x%0h", i, cap_addr[i], lit[i]);
      end
    end
  endtask

  task automatic test_abort();
    set_model('h100, 1, 'h10, 0, 0, 3, 1, 0, 0);
    capture(0, 3, 1'b0);
    checks++;
    if (cap_addr.size() != 3 || cap_end_valid || cap_end_done || cap_end_busy) begin
      failures++;
      $display("FAIL abort: n=%0d valid=%0b done=%0b busy=%0b, required 3 0 0 0", cap_addr.size(), cap_end_valid, cap_end_done, cap_end_busy);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || addr_valid !== 1'b0) begin
        failures++;
        $display("FAIL abort_quiet: done=%b valid=%b, required 0 0", done, addr_valid);
      end
    end
    build_expected();
    capture(0, 0, 1'b0);
    checks++;
    if (cap_addr.size() != exp_q.size() || cap_addr.size() == 0 || cap_addr[0] != 'h100 || !cap_end_done) begin
      failures++;
      $display("FAIL abort_restart: n=%0d first=0x%0h done=%0b, required %0d 0x100 1", cap_addr.size(),
               cap_addr.size() > 0 ? cap_addr[0] : -1, cap_end_done, exp_q.size());
    end
  endtask

  task automatic test_start_abort_same();
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (addr_valid !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL start_abort: valid=%b busy=%b, required 0 0", addr_valid, busy);
      end
    end
  endtask

  task automatic test_disturb();
    set_model('h100, 1, 'h10, 0, 0, 3, 1, 0, 0);
    build_expected();
    capture(2, 0, 1'b1);
    checks++;
    if (cap_timeout || cap_addr.size() != exp_q.size() || !cap_end_done) begin
      failures++;
      $display("FAIL disturb_count: n=%0d done=%0b, required %0d done=1", cap_addr.size(), cap_end_done, exp_q.size());
    end
    for (int i = 0; i < cap_addr.size() && i < exp_q.size(); i++) begin
      checks++;
      if (cap_addr[i] != exp_q[i]) begin
        failures++;
        $display("FAIL disturb_addr[%0d]: got 0x%0h, required 0x%0h", i, cap_addr[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      set_model(int'($urandom_range(0, 8191)),
                int'($urandom_range(0, 8191)), int'($urandom_range(0, 8191)),
                int'($urandom_range(0, 8191)), int'($urandom_range(0, 8191)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      build_expected();
      capture(2, 0, 1'b0);
      checks++;
      if (cap_timeout || cap_addr.size() != exp_q.size() || cap_hold_err != 0 || !cap_end_done) begin
        failures++;
        $display("FAIL rand%0d_ctrl: n=%0d hold_err=%0d done=%0b, required n=%0d 0 1", it, cap_addr.size(), cap_hold_err, cap_end_done, exp_q.size());
      end
      for (int i = 0; i < cap_addr.size() && i < exp_q.size(); i++) begin
        checks++;
        if (cap_addr[i] != exp_q[i] || cap_last[i] != int'(i == exp_q.size() - 1)) begin
          failures++;
          $display("FAIL rand%0d_addr[%0d]: got 0x%0h last=%0d, required 0x%0h last=%0d", it, i, cap_addr[i], cap_last[i],
                   exp_q[i], i == exp_q.size() - 1);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    set_model('h100, 1, 'h10, 0, 0, 3, 1, 0, 0);
    @(posedge clk); #1;
    apply_cfg();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    addr_ready = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({addr_valid, addr_last, busy, done} !== 4'b0 || addr !== '0) begin
      failures++;
      $display("FAIL async_reset: valid=%b last=%b busy=%b done=%b addr=0x%0h, required all 0", addr_valid, addr_last, busy, done, addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || addr_valid !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_after: done=%b valid=%b, required 0 0", done, addr_valid);
    end
    build_expected();
    capture(0, 0, 1'b0);
    checks++;
    if (cap_addr.size() != exp_q.size() || cap_addr.size() == 0 || cap_addr[0] != 'h100) begin
      failures++;
      $display("FAIL async_reset_recover: n=%0d, required %0d starting 0x100", cap_addr.size(), exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_single();
    test_wrap();
    test_abort();
    test_start_abort_same();
    test_disturb();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
